// File: rtl/mem_access_ctrl.sv
// Bus-initiator controller for a 16x8 async-read, level-write memory: one load/store
// request at a time, optional one-level indirection, registered memory pin sequencing.
module mem_access_ctrl #(
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 8,
  parameter int RD_WAIT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_indirect,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] rsp_eff_addr,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out
);

  typedef enum logic [2:0] {
    IDLE,
    PTR_RD,
    DATA_RD,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD,
    RESP
  } state_t;

  localparam logic [2:0] RD_LAST = 3'(RD_WAIT);

  state_t            state, next_state;
  logic              accept, launch, is_read, rd_last;
  logic              op_write, op_indirect;
  logic [ADDR_W-1:0] op_addr, eff_addr, eff_next;
  logic [DATA_W-1:0] op_wdata;
  logic [2:0]        rd_cnt;

  assign accept  = req_valid && req_ready;
  assign is_read = (state == PTR_RD) || (state == DATA_RD);
  assign rd_last = is_read && (rd_cnt == RD_LAST);

  always_comb begin
    next_state = state;
    eff_next   = eff_addr;
    case (state)
      IDLE: begin
        // the accepted request is launched one cycle later, from the captured copy
        if (launch) begin
          if (op_indirect)   next_state = PTR_RD;
          else if (op_write) next_state = WR_SETUP;
          else               next_state = DATA_RD;
        end
      end
      PTR_RD: begin
        if (rd_last) begin
          eff_next   = mem_data_out[ADDR_W-1:0];
          next_state = op_write ? WR_SETUP : DATA_RD;
        end
      end
      DATA_RD:  if (rd_last) next_state = RESP;
      WR_SETUP: next_state = WR_PULSE;
      WR_PULSE: next_state = WR_HOLD;
      WR_HOLD:  next_state = RESP;
      RESP:     if (rsp_valid && rsp_ready) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      launch      <= 1'b0;
      op_write    <= 1'b0;
      op_indirect <= 1'b0;
      op_addr     <= '0;
      op_wdata    <= '0;
      eff_addr    <= '0;
      rd_cnt      <= '0;
    end else begin
      state  <= next_state;
      launch <= accept;
      if (accept) begin
        op_write    <= req_write;
        op_indirect <= req_indirect;
        op_addr     <= req_addr;
        op_wdata    <= req_wdata;
        eff_addr    <= req_addr;
      end else begin
        eff_addr <= eff_next;
      end
      rd_cnt <= (is_read && !rd_last) ? rd_cnt + 3'd1 : '0;
    end
  end

  // Pin registers load from next_state so each pin level coincides with its state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready    <= 1'b1;
      mem_address  <= '0;
      mem_read     <= 1'b0;
      mem_write    <= 1'b0;
      mem_data_in  <= '0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
      rsp_eff_addr <= '0;
    end else begin
      req_ready <= (next_state == IDLE) && !accept;
      mem_read  <= (next_state == PTR_RD) || (next_state == DATA_RD);
      mem_write <= (next_state == WR_PULSE);
      rsp_valid <= (next_state == RESP);
      case (next_state)
        PTR_RD:                              mem_address <= op_addr;
        DATA_RD, WR_SETUP, WR_PULSE, WR_HOLD: mem_address <= eff_next;
        default: ;
      endcase
      if (next_state == WR_SETUP) mem_data_in <= op_wdata;
      if ((state == DATA_RD) && rd_last) rsp_rdata <= mem_data_out;
      if (state == WR_HOLD) rsp_rdata <= op_wdata;
      if ((next_state == RESP) && (state != RESP)) rsp_eff_addr <= eff_addr;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: behavioural memory, reference model of
// effective address / data / latency, and a monitor checking responses and pin timing.
module tb_mem_access_ctrl;
  localparam int AW  = 4;
  localparam int DW  = 8;
  localparam int RDW = 0;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0, req_ready, req_write = 1'b0, req_indirect = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid, rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] rsp_eff_addr, mem_address;
  logic          mem_read, mem_write;
  logic [DW-1:0] mem_data_in, mem_data_out;

  mem_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RD_WAIT(RDW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_indirect(req_indirect), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_eff_addr(rsp_eff_addr), .mem_address(mem_address), .mem_read(mem_read),
    .mem_write(mem_write), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;

  // Behavioural memory: async read, write lands while mem_write is high.
  logic [DW-1:0] mem [16];
  logic          pre_we = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [DW-1:0] pre_data = '0;
  assign mem_data_out = mem[mem_address];
  always @(negedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (mem_write) mem[mem_address] <= mem_data_in;
  end

  typedef struct {
    logic [DW-1:0] rdata;
    logic [AW-1:0] eff;
    int unsigned   edge_no;
  } exp_t;

  exp_t          q[$];
  logic [DW-1:0] ref_mem [16];
  int unsigned   cyc = 0;
  int            total = 0, bad = 0;
  int            rr_mode = 1;  // 0 random, 1 low, 2 high

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(negedge clk);
    rsp_ready = (rr_mode == 0) ? ($urandom_range(0, 2) != 0) : (rr_mode == 2);
  end

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(posedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    #1 pre_we = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic issue(input logic w, input logic ind, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, output int unsigned acc);
    int unsigned n = 0;
    logic [AW-1:0] eff;
    exp_t e;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_indirect = ind; req_addr = a; req_wdata = d;
    while (!req_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      acc = 0;
      return;
    end
    @(posedge clk);
    #1 acc = cyc;
    req_valid = 1'b0;
    req_addr  = AW'($urandom);
    req_wdata = DW'($urandom);
    eff = ind ? ref_mem[a][AW-1:0] : a;
    if (w) begin
      ref_mem[eff] = d;
      e.rdata = d;
    end else begin
      e.rdata = ref_mem[eff];
    end
    e.eff = eff;
    e.edge_no = acc + 2 + (ind ? 1 + RDW : 0) + (w ? 2 : RDW);
    q.push_back(e);
  endtask

  task automatic drain();
    int unsigned n = 0;
    while (q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) chk("drain_timeout", q.size(), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  // Monitor: pin-level rules every cycle, response compare on each new rsp_valid.
  exp_t        cur;
  logic        seen = 1'b0;
  int unsigned wr_cnt = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      seen   = 1'b0;
      wr_cnt = 0;
    end else begin
      chk("rd_wr_exclusive", {31'd0, mem_read & mem_write}, 32'd0);
      if (mem_write) begin
        wr_cnt++;
        if (q.size() == 0) chk("write_without_op", 32'd0, 32'd1);
        else begin
          chk("write_addr", mem_address, q[0].eff);
          chk("write_data", mem_data_in, q[0].rdata);
        end
      end else if (wr_cnt != 0) begin
        chk("write_pulse_width", wr_cnt, 32'd1);
        if (q.size() != 0) chk("hold_addr", mem_address, q[0].eff);
        wr_cnt = 0;
      end
      if (req_ready) chk("ready_with_outstanding", q.size(), 32'd0);
      if (rsp_valid) begin
        chk("ready_low_in_resp", req_ready, 32'd0);
        if (!seen) begin
          if (q.size() == 0) chk("spurious_rsp", 32'd1, 32'd0);
          else begin
            cur  = q.pop_front();
            seen = 1'b1;
            chk("rsp_rdata", rsp_rdata, cur.rdata);
            chk("rsp_eff_addr", rsp_eff_addr, cur.eff);
            chk("rsp_latency", cyc, cur.edge_no);
          end
        end else begin
          chk("rsp_rdata_stable", rsp_rdata, cur.rdata);
          chk("rsp_eff_stable", rsp_eff_addr, cur.eff);
        end
      end else begin
        seen = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (total=%0d bad=%0d)", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned acc, acc2, hs, n;
    #1;
    chk("reset_mem_read", mem_read, 32'd0);
    chk("reset_mem_write", mem_write, 32'd0);
    chk("reset_rsp_valid", rsp_valid, 32'd0);
    chk("reset_mem_address", mem_address, 32'd0);
    chk("reset_mem_data_in", mem_data_in, 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'd0);
    chk("reset_rsp_eff", rsp_eff_addr, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 chk("ready_after_reset", req_ready, 32'd1);

    for (int i = 0; i < 16; i++) preload(AW'(i), DW'($urandom));
    rr_mode = 2;

    preload(4'hA, 8'h02);
    issue(1'b0, 1'b0, 4'hA, 8'h00, acc);
    drain();
    preload(4'hC, 8'h09);
    preload(4'h9, 8'h08);
    issue(1'b0, 1'b1, 4'hC, 8'h00, acc);
    drain();
    preload(4'h0, 8'h4C);
    issue(1'b0, 1'b1, 4'h0, 8'h00, acc);
    drain();
    issue(1'b1, 1'b0, 4'h3, 8'h5A, acc);
    issue(1'b0, 1'b0, 4'h3, 8'h00, acc);
    drain();
    issue(1'b1, 1'b1, 4'hC, 8'hE7, acc);
    drain();

    // Backpressure with a second request waiting.
    @(posedge clk);
    #1 rr_mode = 1;
    issue(1'b0, 1'b0, 4'hA, 8'h00, acc);
    hs = 0;
    acc2 = 0;
    fork
      issue(1'b0, 1'b0, 4'h3, 8'h00, acc2);
      begin
        n = 0;
        while (!rsp_valid && n < 50) begin
          @(negedge clk);
          n++;
        end
        if (!rsp_valid) chk("bp_rsp_timeout", 32'd0, 32'd1);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 rr_mode = 2;
        @(posedge clk);
        #1 hs = cyc;
      end
    join
    chk("bp_second_accept", acc2, hs + 1);
    drain();

    rr_mode = 0;
    for (int i = 0; i < 40; i++)
      issue(1'($urandom), 1'($urandom), AW'($urandom), DW'($urandom), acc);
    drain();

    // Reset while the write pulse is on the pins.
    rr_mode = 2;
    issue(1'b1, 1'b0, 4'h5, 8'h77, acc);
    n = 0;
    while (!mem_write && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("wait_write_pulse", mem_write, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mem_write", mem_write, 32'd0);
    chk("rst_mem_read", mem_read, 32'd0);
    chk("rst_rsp_valid", rsp_valid, 32'd0);
    chk("rst_mem_address", mem_address, 32'd0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 chk("ready_after_midop_reset", req_ready, 32'd1);
    repeat (6) @(negedge clk);
    issue(1'b0, 1'b0, 4'h5, 8'h00, acc);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Bus-initiator side of the CPU's 16x8 asynchronous-read, level-write memory.
- Accepts single load/store requests from the CPU datapath over a valid/ready handshake. Supports direct and one-level indirect addressing (M[M[a]]).
- Sequences the memory's address/read/write/data_in/data_out pins with safe setup/pulse/hold timing.
- Returns the result over a valid/ready response channel.

Parameters:
- ADDR_W, 4, memory address width. Effective address is the low ADDR_W bits of a pointer.
- DATA_W, 8, memory data width.
- RD_WAIT, 0, extra cycles the read stays asserted before data_out is sampled (0..7).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  CPU request present.
- req_ready  out  1  controller can accept; high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_indirect  in  1  1 = req_addr points to a pointer word.
- req_addr  in  ADDR_W  request address.
- req_wdata  in  DATA_W  store data.
- rsp_valid  out  1  response present; held until rsp_ready.
- rsp_ready  in  1  CPU accepts response.
- rsp_rdata  out  DATA_W  load data, or echoed store data.
- rsp_eff_addr  out  ADDR_W  effective address actually accessed.
- mem_address  out  ADDR_W  to memory address.
- mem_read  out  1  to memory read.
- mem_write  out  1  to memory write.
- mem_data_in  out  DATA_W  to memory data_in.
- mem_data_out  in  DATA_W  from memory data_out.

Behaviour:
- All outputs are registered.
- Reset (async, rst_n=0):
  - State is IDLE.
  - mem_address, mem_data_in, rsp_rdata and rsp_eff_addr are 0.
  - mem_read, mem_write and rsp_valid are 0.
  - req_ready is 1 once rst_n deasserts.
- Request acceptance:
  - A request is accepted on a rising edge with req_valid&req_ready.
  - req_write, req_indirect, req_addr and req_wdata are captured at that edge.
  - Inputs are ignored outside IDLE.
- States: IDLE, PTR_RD, DATA_RD, WR_SETUP, WR_PULSE, WR_HOLD, RESP.
- IDLE -> PTR_RD if indirect, else DATA_RD (load) or WR_SETUP (store).
- PTR_RD:
  - mem_address = req_addr, mem_read = 1, for RD_WAIT+1 cycles.
  - On the last cycle, the effective address is mem_data_out[ADDR_W-1:0]; upper pointer bits are discarded.
  - Next state is DATA_RD (load) or WR_SETUP (store).
- DATA_RD:
  - mem_address = eff addr, mem_read = 1, for RD_WAIT+1 cycles.
  - mem_data_out is sampled into rsp_rdata on the last cycle.
  - Next state is RESP.
- WR_SETUP: mem_address = eff addr, mem_data_in = wdata, mem_write = 0, for 1 cycle.
- WR_PULSE: mem_write = 1 for exactly 1 cycle; address and data unchanged.
- WR_HOLD: mem_write = 0 for 1 cycle; address and data unchanged. Next state is RESP, with rsp_rdata = wdata.
- Read/write exclusivity:
  - mem_read and mem_write are never high together.
  - mem_read is low in all non-read states.
  - mem_address never changes while mem_write = 1.
- RESP:
  - rsp_valid = 1, with rsp_rdata and rsp_eff_addr stable, until rsp_ready is sampled high.
  - After that handshake: IDLE, rsp_valid = 0.
  - req_ready stays 0 during RESP, so there is no overlap with a new request.
- Latency (RD_WAIT=0, rsp_ready tied high; acceptance at edge n; rsp_valid high from edge listed):
  - direct load: n+2.
  - indirect load: n+3.
  - direct store: n+4.
  - indirect store: n+5.
- Each RD_WAIT adds 1 cycle per read phase.
- The effective address always wraps modulo 2^ADDR_W; there is no range error.
- Reset mid-operation: all outputs drop immediately (mem_write included), state is IDLE, and no response is issued. A write in progress may or may not have landed in memory.

Test Plan:
- Memory preloaded M[10]=0x02; direct load addr 0xA -> rsp_rdata=0x02, rsp_eff_addr=0xA, rsp_valid at acceptance+2.
- M[12]=0x09, M[9]=0x08; indirect load addr 0xC -> eff 0x9, rsp_rdata=0x08, rsp_valid at acceptance+3.
- Pointer with upper bits: M[0]=0x4C, M[12]=0x09; indirect load addr 0x0 -> eff 0xC, rsp_rdata=0x09.
- Direct store 0x5A to addr 0x3, then direct load addr 0x3:
  - Expect mem_write high exactly 1 cycle, with mem_address=0x3 stable from WR_SETUP through WR_HOLD.
  - Load returns 0x5A.
  - mem_read=mem_write=1 never occurs.
- Backpressure:
  - Hold rsp_ready low 3 cycles after rsp_valid, and drive req_valid with a second request.
  - rsp_valid and rsp_rdata stay stable and req_ready stays 0.
  - The second request is accepted only in the cycle after the rsp handshake.
- Reset during WR_PULSE: rst_n low -> mem_write/mem_read/rsp_valid all 0 immediately (same cycle). After release, req_ready=1 and no spurious rsp_valid.
